// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and constants for the DRAM port arbiter.
//   arb_state_e   FSM encoding, also exported on ArbState for debug
//   strobes_t     select/strobe bundle muxed from the owning requester
//   STROBES_IDLE  all strobes deasserted (active-low signals high)
package dram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT0  = 2'd1,
    ST_GRANT1  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_TIMEOUT    = 1023;
  localparam int DEF_GAP_CYCLES = 1;
  localparam int WD_W           = 10;

  typedef struct packed {
    logic sel_l;
    logic as_l;
    logic we_l;
    logic uds_l;
    logic lds_l;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = strobes_t'(5'b11111);

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick.
//   req   in  2  request vector
//   last  in  1  index of the most recent owner
//   gnt   out 2  one-hot winner, 00 when nobody requests
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;  // tie goes to whoever did not go last
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one DRAM controller port between two bus masters.
//   Clock, Reset_L            clock, synchronous active-low reset
//   Req0_* / Req1_*           requester strobes, address, write data, DTACK back
//   DramSelect_L..DataOut     muxed bus towards the DRAM controller
//   DtackFromDram_L           DTACK from the DRAM controller
//   Grant, ArbState           one-hot owner and FSM state (debug)
//   Timeout_H                 sticky watchdog flag, cleared only by reset
// Ownership lasts a whole bus cycle (AS_L low to AS_L high); a RELEASE gap
// separates consecutive owners so the DRAM controller sees its strobes idle.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              Clock,
  input  logic              Reset_L,
  input  logic              Req0_Select_L,
  input  logic              Req0_AS_L,
  input  logic              Req0_WE_L,
  input  logic              Req0_UDS_L,
  input  logic              Req0_LDS_L,
  input  logic [ADDR_W-1:0] Req0_Address,
  input  logic [DATA_W-1:0] Req0_DataOut,
  output logic              Req0_Dtack_L,
  input  logic              Req1_Select_L,
  input  logic              Req1_AS_L,
  input  logic              Req1_WE_L,
  input  logic              Req1_UDS_L,
  input  logic              Req1_LDS_L,
  input  logic [ADDR_W-1:0] Req1_Address,
  input  logic [DATA_W-1:0] Req1_DataOut,
  output logic              Req1_Dtack_L,
  output logic              DramSelect_L,
  output logic              AS_L,
  output logic              WE_L,
  output logic              UDS_L,
  output logic              LDS_L,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] DataOut,
  input  logic              DtackFromDram_L,
  output logic [1:0]        Grant,
  output logic              Timeout_H,
  output logic [1:0]        ArbState
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_e        state, state_nxt;
  logic              req0, req1;
  logic              last_grant;
  logic [1:0]        pick;
  logic              in_grant, owner_active, wd_fire, gap_last;
  logic [WD_W-1:0]   wd_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  strobes_t          s0, s1, s_out;

  assign req0 = !Req0_Select_L && !Req0_AS_L;
  assign req1 = !Req1_Select_L && !Req1_AS_L;

  assign s0 = {Req0_Select_L, Req0_AS_L, Req0_WE_L, Req0_UDS_L, Req0_LDS_L};
  assign s1 = {Req1_Select_L, Req1_AS_L, Req1_WE_L, Req1_UDS_L, Req1_LDS_L};

  assign in_grant     = (state == ST_GRANT0) || (state == ST_GRANT1);
  assign owner_active = (state == ST_GRANT1) ? req1 : req0;
  // Fires on the edge that would complete TIMEOUT DTACK-less cycles in the grant.
  assign wd_fire      = DtackFromDram_L && (wd_cnt >= WD_W'(TIMEOUT - 1));
  assign gap_last     = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  rr_arbiter2 u_rr (
    .req  ({req1, req0}),
    .last (last_grant),
    .gnt  (pick)
  );

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset_L) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state: release always wins over a competing request so the
  // DRAM controller gets its idle gap between owners.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick[0])      state_nxt = ST_GRANT0;
        else if (pick[1]) state_nxt = ST_GRANT1;
      end
      ST_GRANT0, ST_GRANT1: begin
        if (!owner_active || wd_fire) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (gap_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: owner's bus passes through combinationally; everything else idle.
  always_comb begin
    s_out        = STROBES_IDLE;
    Address      = '0;
    DataOut      = '0;
    Req0_Dtack_L = 1'b1;
    Req1_Dtack_L = 1'b1;
    Grant        = 2'b00;
    case (state)
      ST_GRANT0: begin
        s_out        = s0;
        Address      = Req0_Address;
        DataOut      = Req0_DataOut;
        Req0_Dtack_L = DtackFromDram_L;
        Grant        = 2'b01;
      end
      ST_GRANT1: begin
        s_out        = s1;
        Address      = Req1_Address;
        DataOut      = Req1_DataOut;
        Req1_Dtack_L = DtackFromDram_L;
        Grant        = 2'b10;
      end
      default: ;
    endcase
  end

  assign {DramSelect_L, AS_L, WE_L, UDS_L, LDS_L} = s_out;
  assign ArbState = state;

  // LastGrant, watchdog, gap counter, sticky timeout flag
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      last_grant <= 1'b1;  // req0 wins the first tie
      wd_cnt     <= '0;
      gap_cnt    <= '0;
      Timeout_H  <= 1'b0;
    end else begin
      if (in_grant && state_nxt == ST_RELEASE)
        last_grant <= (state == ST_GRANT1);
      if (in_grant && owner_active && wd_fire)
        Timeout_H <= 1'b1;
      // Zero outside a grant, so every grant starts from a clean count.
      if (!in_grant || !DtackFromDram_L) wd_cnt <= '0;
      else if (wd_cnt != '1)             wd_cnt <= wd_cnt + 1'b1;
      if (state == ST_RELEASE && !gap_last) gap_cnt <= gap_cnt + 1'b1;
      else                                  gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;

  logic        Clock = 1'b0;
  logic        Reset_L;
  logic        r0_sel, r0_as, r0_we, r0_uds, r0_lds;
  logic [31:0] r0_addr;
  logic [15:0] r0_dout;
  logic        r1_sel, r1_as, r1_we, r1_uds, r1_lds;
  logic [31:0] r1_addr;
  logic [15:0] r1_dout;
  logic        Req0_Dtack_L, Req1_Dtack_L;
  logic        DramSelect_L, AS_L, WE_L, UDS_L, LDS_L;
  logic [31:0] Address;
  logic [15:0] DataOut;
  logic        DtackFromDram_L;
  logic [1:0]  Grant;
  logic        Timeout_H;
  logic [1:0]  ArbState;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  dram_port_arbiter #(.ADDR_W(32), .DATA_W(16), .TIMEOUT(15), .GAP_CYCLES(1)) dut (
    .Clock(Clock), .Reset_L(Reset_L),
    .Req0_Select_L(r0_sel), .Req0_AS_L(r0_as), .Req0_WE_L(r0_we),
    .Req0_UDS_L(r0_uds), .Req0_LDS_L(r0_lds), .Req0_Address(r0_addr),
    .Req0_DataOut(r0_dout), .Req0_Dtack_L(Req0_Dtack_L),
    .Req1_Select_L(r1_sel), .Req1_AS_L(r1_as), .Req1_WE_L(r1_we),
    .Req1_UDS_L(r1_uds), .Req1_LDS_L(r1_lds), .Req1_Address(r1_addr),
    .Req1_DataOut(r1_dout), .Req1_Dtack_L(Req1_Dtack_L),
    .DramSelect_L(DramSelect_L), .AS_L(AS_L), .WE_L(WE_L), .UDS_L(UDS_L),
    .LDS_L(LDS_L), .Address(Address), .DataOut(DataOut),
    .DtackFromDram_L(DtackFromDram_L), .Grant(Grant), .Timeout_H(Timeout_H),
    .ArbState(ArbState)
  );

  localparam logic [31:0] A0 = 32'h0800_0010, A1 = 32'h0C00_0200;
  localparam logic [15:0] D0 = 16'h1234, D1 = 16'hBEEF;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive_req(input int n, input logic on, input logic [31:0] addr,
                           input logic [15:0] data, input logic we_l);
    if (n == 0) begin
      r0_sel = !on; r0_as = !on; r0_uds = !on; r0_lds = !on;
      r0_we = on ? we_l : 1'b1; r0_addr = addr; r0_dout = data;
    end else begin
      r1_sel = !on; r1_as = !on; r1_uds = !on; r1_lds = !on;
      r1_we = on ? we_l : 1'b1; r1_addr = addr; r1_dout = data;
    end
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    Reset_L = 1'b0;
    tick(); tick();
    Reset_L = 1'b1;
    tick();
    obs = {DramSelect_L, AS_L, WE_L, UDS_L, LDS_L, Req0_Dtack_L, Req1_Dtack_L};
    checks++;
    if (obs !== 7'h7F || Address !== 32'h0 || DataOut !== 16'h0 || Grant !== 2'b00) begin
      errors++; $display("FAIL reset_idle: strobes=%b addr=%h data=%h grant=%b, want 1111111/0/0/00", obs, Address, DataOut, Grant);
    end
    checks++;
    if (ArbState !== 2'd0 || Timeout_H !== 1'b0) begin
      errors++; $display("FAIL reset_state: state=%0d to=%b, want 0/0", ArbState, Timeout_H);
    end
    drive_req(0, 1'b1, 32'h0000_1234, D0, 1'b1);
    tick();
    checks++;
    if (Grant !== 2'b01) begin
      errors++; $display("FAIL reset_pregrant: grant=%b want 01", Grant);
    end
    DtackFromDram_L = 1'b0;
    Reset_L = 1'b0;
    tick();
    obs = {DramSelect_L, AS_L, WE_L, UDS_L, LDS_L, Req0_Dtack_L, Req1_Dtack_L};
    checks++;
    if (obs !== 7'h7F || Grant !== 2'b00 || Timeout_H !== 1'b0) begin
      errors++; $display("FAIL reset_midgrant: strobes=%b grant=%b to=%b, want 1111111/00/0", obs, Grant, Timeout_H);
    end
    tick(); tick();
    DtackFromDram_L = 1'b1;
    drive_req(0, 1'b0, 32'h0, 16'h0, 1'b1);
    Reset_L = 1'b1;
    tick();
    checks++;
    if (ArbState !== 2'd0 || AS_L !== 1'b1) begin
      errors++; $display("FAIL reset_exit: state=%0d as=%b, want 0/1", ArbState, AS_L);
    end
  endtask

  task automatic test_req0_only();
    logic exp_dt;
    drive_req(0, 1'b1, A0, D0, 1'b1);
    checks++;
    if (AS_L !== 1'b1 || Grant !== 2'b00) begin
      errors++; $display("FAIL req0_registered: as=%b grant=%b before edge, want 1/00", AS_L, Grant);
    end
    tick();
    checks++;
    if (Grant !== 2'b01 || Address !== A0 || AS_L !== 1'b0 || DramSelect_L !== 1'b0 || WE_L !== 1'b1) begin
      errors++; $display("FAIL req0_grant: grant=%b addr=%h as=%b sel=%b we=%b, want 01/%h/0/0/1", Grant, Address, AS_L, DramSelect_L, WE_L, A0);
    end
    for (int i = 1; i <= 10; i++) begin
      exp_dt = (i % 3 == 0) ? 1'b0 : 1'b1;
      DtackFromDram_L = exp_dt;
      #1;
      checks++;
      if (Req0_Dtack_L !== exp_dt || Req1_Dtack_L !== 1'b1 || Grant !== 2'b01) begin
        errors++; $display("FAIL req0_dtack[%0d]: d0=%b d1=%b grant=%b, want %b/1/01", i, Req0_Dtack_L, Req1_Dtack_L, Grant, exp_dt);
      end
      tick();
    end
    drive_req(0, 1'b0, 32'h0, 16'h0, 1'b1);
    DtackFromDram_L = 1'b1;
    tick();
    checks++;
    if (ArbState !== 2'd3 || AS_L !== 1'b1 || Address !== 32'h0 || Grant !== 2'b00) begin
      errors++; $display("FAIL req0_release: state=%0d as=%b addr=%h grant=%b, want 3/1/0/00", ArbState, AS_L, Address, Grant);
    end
    tick();
    checks++;
    if (ArbState !== 2'd0) begin
      errors++; $display("FAIL req0_idle: state=%0d want 0", ArbState);
    end
  endtask

  task automatic test_tie();
    logic [6:0] obs;
    Reset_L = 1'b0;
    tick();
    Reset_L = 1'b1;
    drive_req(0, 1'b1, A0, D0, 1'b1);
    drive_req(1, 1'b1, A1, D1, 1'b0);
    tick();
    checks++;
    if (Grant !== 2'b01 || Address !== A0) begin
      errors++; $display("FAIL tie_first: grant=%b addr=%h, want 01/%h", Grant, Address, A0);
    end
    DtackFromDram_L = 1'b0;
    #1;
    checks++;
    if (Req0_Dtack_L !== 1'b0 || Req1_Dtack_L !== 1'b1) begin
      errors++; $display("FAIL tie_dtack_route: d0=%b d1=%b, want 0/1", Req0_Dtack_L, Req1_Dtack_L);
    end
    tick(); tick(); tick();
    checks++;
    if (Grant !== 2'b01 || Req1_Dtack_L !== 1'b1) begin
      errors++; $display("FAIL tie_hold: grant=%b d1=%b, want 01/1", Grant, Req1_Dtack_L);
    end
    drive_req(0, 1'b0, 32'h0, 16'h0, 1'b1);
    DtackFromDram_L = 1'b1;
    tick();
    obs = {DramSelect_L, AS_L, WE_L, UDS_L, LDS_L, Req0_Dtack_L, Req1_Dtack_L};
    checks++;
    if (ArbState !== 2'd3 || obs !== 7'h7F) begin
      errors++; $display("FAIL tie_gap: state=%0d strobes=%b, want 3/1111111", ArbState, obs);
    end
    tick();
    checks++;
    if (ArbState !== 2'd0 || AS_L !== 1'b1 || Grant !== 2'b00) begin
      errors++; $display("FAIL tie_gap_idle: state=%0d as=%b grant=%b, want 0/1/00", ArbState, AS_L, Grant);
    end
    tick();
    checks++;
    if (Grant !== 2'b10 || Address !== A1 || WE_L !== 1'b0 || DataOut !== D1) begin
      errors++; $display("FAIL tie_second: grant=%b addr=%h we=%b data=%h, want 10/%h/0/%h", Grant, Address, WE_L, DataOut, A1, D1);
    end
    drive_req(1, 1'b0, 32'h0, 16'h0, 1'b1);
    tick(); tick();
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    int          n, own;
    drive_req(0, 1'b1, A0, D0, 1'b1);
    drive_req(1, 1'b1, A1, D1, 1'b1);
    DtackFromDram_L = 1'b0;
    for (int k = 0; k < 4; k++) begin
      own   = k % 2;
      exp_g = (own == 0) ? 2'b01 : 2'b10;
      exp_a = (own == 0) ? A0 : A1;
      n = 0;
      while (Grant === 2'b00 && n < 10) begin tick(); n++; end
      checks++;
      if (Grant !== exp_g || Address !== exp_a) begin
        errors++; $display("FAIL fair_grant[%0d]: grant=%b addr=%h, want %b/%h", k, Grant, Address, exp_g, exp_a);
      end
      tick(); tick(); tick();
      drive_req(own, 1'b0, 32'h0, 16'h0, 1'b1);
      tick();
      drive_req(own, 1'b1, exp_a, (own == 0) ? D0 : D1, 1'b1);
      tick();
    end
    drive_req(0, 1'b0, 32'h0, 16'h0, 1'b1);
    drive_req(1, 1'b0, 32'h0, 16'h0, 1'b1);
    DtackFromDram_L = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (ArbState !== 2'd0) begin
      errors++; $display("FAIL fair_end: state=%0d want 0", ArbState);
    end
  endtask

  task automatic test_watchdog();
    int n;
    DtackFromDram_L = 1'b1;
    drive_req(1, 1'b1, A1, D1, 1'b1);
    tick();
    checks++;
    if (Grant !== 2'b10 || Timeout_H !== 1'b0) begin
      errors++; $display("FAIL wd_grant: grant=%b to=%b, want 10/0", Grant, Timeout_H);
    end
    n = 1;
    while (ArbState === 2'd2 && n < 40) begin tick(); if (ArbState === 2'd2) n++; end
    checks++;
    if (n !== 15 || ArbState !== 2'd3 || Timeout_H !== 1'b1) begin
      errors++; $display("FAIL wd_fire: grant clks=%0d state=%0d to=%b, want 15/3/1", n, ArbState, Timeout_H);
    end
    drive_req(1, 1'b0, 32'h0, 16'h0, 1'b1);
    tick(); tick();
    checks++;
    if (Timeout_H !== 1'b1 || ArbState !== 2'd0) begin
      errors++; $display("FAIL wd_sticky: to=%b state=%0d, want 1/0", Timeout_H, ArbState);
    end
  endtask

  task automatic test_burst();
    logic exp_dt;
    int   beats = 0;
    drive_req(0, 1'b1, A0, D0, 1'b1);
    tick();
    drive_req(1, 1'b1, A1, D1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      exp_dt = (i >= 1) ? 1'b0 : 1'b1;
      DtackFromDram_L = exp_dt;
      #1;
      if (Req0_Dtack_L === 1'b0) beats++;
      checks++;
      if (Grant !== 2'b01 || Address !== A0 || Req0_Dtack_L !== exp_dt || Req1_Dtack_L !== 1'b1) begin
        errors++; $display("FAIL burst_beat[%0d]: grant=%b addr=%h d0=%b d1=%b, want 01/%h/%b/1", i, Grant, Address, Req0_Dtack_L, Req1_Dtack_L, A0, exp_dt);
      end
      tick();
    end
    checks++;
    if (beats !== 8) begin
      errors++; $display("FAIL burst_count: beats=%0d want 8", beats);
    end
    drive_req(0, 1'b0, 32'h0, 16'h0, 1'b1);
    DtackFromDram_L = 1'b1;
    tick();
    checks++;
    if (ArbState !== 2'd3 || Grant !== 2'b00) begin
      errors++; $display("FAIL burst_release: state=%0d grant=%b, want 3/00", ArbState, Grant);
    end
    tick(); tick();
    checks++;
    if (Grant !== 2'b10 || Address !== A1 || DataOut !== D1) begin
      errors++; $display("FAIL burst_next: grant=%b addr=%h data=%h, want 10/%h/%h", Grant, Address, DataOut, A1, D1);
    end
    drive_req(1, 1'b0, 32'h0, 16'h0, 1'b1);
    tick(); tick();
    checks++;
    if (Timeout_H !== 1'b1) begin
      errors++; $display("FAIL burst_to_sticky: to=%b want 1", Timeout_H);
    end
  endtask

  task automatic test_final_reset();
    Reset_L = 1'b0;
    tick();
    checks++;
    if (Timeout_H !== 1'b0 || ArbState !== 2'd0) begin
      errors++; $display("FAIL final_reset: to=%b state=%0d, want 0/0", Timeout_H, ArbState);
    end
    Reset_L = 1'b1;
    tick();
  endtask

  initial begin
    Reset_L = 1'b0;
    DtackFromDram_L = 1'b1;
    drive_req(0, 1'b0, 32'h0, 16'h0, 1'b1);
    drive_req(1, 1'b0, 32'h0, 16'h0, 1'b1);
    test_reset();
    test_req0_only();
    test_tie();
    test_fairness();
    test_watchdog();
    test_burst();
    test_final_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
